// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the LSU stage: mem_op encodings, trap causes, FSM states,
// writeback bundle layout and small mem_op decode helpers.
package lsu_stage_pkg;

    localparam int unsigned DATA_W = 64;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LD   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_LHU  = 4'd6,
        MEM_LWU  = 4'd7,
        MEM_SB   = 4'd8,
        MEM_SH   = 4'd9,
        MEM_SW   = 4'd10,
        MEM_SD   = 4'd11
    } mem_op_e;

    localparam logic [DATA_W-1:0] BREAKPOINT       = 64'd3;
    localparam logic [DATA_W-1:0] LOAD_MISALIGNED  = 64'd4;
    localparam logic [DATA_W-1:0] STORE_MISALIGNED = 64'd6;
    localparam logic [DATA_W-1:0] ECALL_U          = 64'd8;
    localparam logic [DATA_W-1:0] ECALL_S          = 64'd9;
    localparam logic [DATA_W-1:0] ECALL_M          = 64'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [4:0]        rd;
        logic [DATA_W-1:0] wdata;
        logic              csr_wen;
        logic [11:0]       csr_addr;
        logic [DATA_W-1:0] csr_wdata;
        logic              exception;
        logic [DATA_W-1:0] cause;
        logic [DATA_W-1:0] pc;
    } wb_t;

    function automatic logic op_is_load(logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_LWU);
    endfunction

    function automatic logic op_is_store(logic [3:0] op);
        return (op >= MEM_SB) && (op <= MEM_SD);
    endfunction

    function automatic logic op_is_mem(logic [3:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(logic [3:0] op);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
            MEM_LW, MEM_LWU, MEM_SW: return 2'd2;
            MEM_LD, MEM_SD:          return 2'd3;
            default:                 return 2'd0;
        endcase
    endfunction

    function automatic logic op_misaligned(logic [3:0] op, logic [2:0] off);
        case (op_size(op))
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            2'd3:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Request/grant/response data-memory port between the LSU (master) and memory (slave).
interface lsu_stage_if #(
    parameter int unsigned XLEN = 64
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN/8-1:0] dmem_wmask;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: load lane select with sign/zero extension,
// store byte-mask generation and data shift into the addressed lanes.
module lsu_align
    import lsu_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [3:0]        op_i,
    input  logic [2:0]        off_i,
    input  logic [XLEN-1:0]   rdata_i,
    input  logic [XLEN-1:0]   store_data_i,
    output logic [XLEN-1:0]   load_data_o,
    output logic [XLEN-1:0]   store_wdata_o,
    output logic [XLEN/8-1:0] wmask_o
);

    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0] lane;
    logic [NB-1:0]   base_mask;

    always_comb begin
        lane        = rdata_i >> {off_i, 3'b000};
        load_data_o = lane;
        case (op_i)
            MEM_LB:  load_data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
            MEM_LH:  load_data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
            MEM_LW:  load_data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
            MEM_LBU: load_data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
            MEM_LHU: load_data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
            MEM_LWU: load_data_o = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: load_data_o = lane;
        endcase

        case (op_size(op_i))
            2'd1:    base_mask = NB'(8'h03);
            2'd2:    base_mask = NB'(8'h0F);
            2'd3:    base_mask = '1;
            default: base_mask = NB'(8'h01);
        endcase
        wmask_o       = base_mask << off_i;
        store_wdata_o = store_data_i << {off_i, 3'b000};
    end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access pipeline stage: runs one load/store at a time over the dmem port,
// traps misaligned accesses and registers the writeback bundle.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [3:0]      mem_op_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            wen_i,
    input  logic [4:0]      rd_i,
    input  logic            csr_wen_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            exception_i,
    input  logic [XLEN-1:0] cause_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            stall_o,
    lsu_stage_if.master     dmem,
    output logic            valid_o,
    output logic            wen_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            csr_wen_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            exception_o,
    output logic [XLEN-1:0] cause_o,
    output logic [XLEN-1:0] pc_o
);

    state_e            state_q, state_d;
    logic [3:0]        op_q;
    logic [XLEN-1:0]   addr_q, sdata_q;
    wb_t               ctx_q, ctx_d;
    wb_t               wb_q, wb_d;
    logic              accept;
    logic [XLEN-1:0]   load_data, st_wdata;
    logic [XLEN/8-1:0] st_wmask;
    logic              in_req;

    lsu_align #(.XLEN(XLEN)) u_align (
        .op_i          (op_q),
        .off_i         (addr_q[2:0]),
        .rdata_i       (dmem.dmem_rdata),
        .store_data_i  (sdata_q),
        .load_data_o   (load_data),
        .store_wdata_o (st_wdata),
        .wmask_o       (st_wmask)
    );

    always_comb begin
        state_d = state_q;
        wb_d    = '0;
        stall_o = 1'b0;
        accept  = 1'b0;

        // Bundle fields that ride along with an accepted memory op until it retires
        ctx_d           = '0;
        ctx_d.wen       = wen_i;
        ctx_d.rd        = rd_i;
        ctx_d.wdata     = addr_i;
        ctx_d.csr_wen   = csr_wen_i;
        ctx_d.csr_addr  = csr_addr_i;
        ctx_d.csr_wdata = csr_wdata_i;
        ctx_d.pc        = pc_i;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    wb_d.valid     = 1'b1;
                    wb_d.rd        = rd_i;
                    wb_d.wdata     = addr_i;
                    wb_d.csr_addr  = csr_addr_i;
                    wb_d.csr_wdata = csr_wdata_i;
                    wb_d.pc        = pc_i;
                    if (exception_i) begin
                        wb_d.exception = 1'b1;
                        wb_d.cause     = cause_i;
                    end else if (!op_is_mem(mem_op_i)) begin
                        wb_d.wen     = wen_i;
                        wb_d.csr_wen = csr_wen_i;
                    end else if (op_misaligned(mem_op_i, addr_i[2:0])) begin
                        wb_d.exception = 1'b1;
                        wb_d.cause     = op_is_store(mem_op_i) ? STORE_MISALIGNED : LOAD_MISALIGNED;
                    end else begin
                        wb_d    = '0;
                        stall_o = 1'b1;
                        accept  = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_o = 1'b1;
                if (dmem.dmem_gnt) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (dmem.dmem_rvalid) begin
                    state_d    = ST_IDLE;
                    wb_d       = ctx_q;
                    wb_d.valid = 1'b1;
                    if (op_is_load(op_q)) wb_d.wdata = load_data;
                    else                  wb_d.wen   = 1'b0;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            ctx_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            if (accept) begin
                op_q    <= mem_op_i;
                addr_q  <= addr_i;
                sdata_q <= store_data_i;
                ctx_q   <= ctx_d;
            end
        end
    end

    assign in_req          = (state_q == ST_REQ);
    assign dmem.dmem_req   = in_req;
    assign dmem.dmem_we    = in_req && op_is_store(op_q);
    assign dmem.dmem_addr  = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign dmem.dmem_wdata = in_req ? st_wdata : '0;
    assign dmem.dmem_wmask = in_req ? st_wmask : '0;

    assign valid_o     = wb_q.valid;
    assign wen_o       = wb_q.wen;
    assign rd_o        = wb_q.rd;
    assign wdata_o     = wb_q.wdata;
    assign csr_wen_o   = wb_q.csr_wen;
    assign csr_addr_o  = wb_q.csr_addr;
    assign csr_wdata_o = wb_q.csr_wdata;
    assign exception_o = wb_q.exception;
    assign cause_o     = wb_q.cause;
    assign pc_o        = wb_q.pc;

endmodule

// File: tb/tb_lsu_stage.sv
// Randomized scoreboard bench for lsu_stage: expected bundles and memory
// transactions are queued at issue and checked by independent monitor/responder.
module tb_lsu_stage;
    import lsu_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic [3:0]  mem_op_i = '0;
    logic [63:0] addr_i = '0, store_data_i = '0;
    logic        wen_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic        csr_wen_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic [63:0] csr_wdata_i = '0;
    logic        exception_i = 1'b0;
    logic [63:0] cause_i = '0, pc_i = '0;
    logic        stall_o;
    logic        valid_o, wen_o, csr_wen_o, exception_o;
    logic [4:0]  rd_o;
    logic [11:0] csr_addr_o;
    logic [63:0] wdata_o, csr_wdata_o, cause_o, pc_o;

    lsu_stage_if #(.XLEN(64)) dmem ();

    lsu_stage #(.XLEN(64)) dut (
        .clock(clock), .reset(reset), .valid_i(valid_i), .mem_op_i(mem_op_i),
        .addr_i(addr_i), .store_data_i(store_data_i), .wen_i(wen_i), .rd_i(rd_i),
        .csr_wen_i(csr_wen_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .exception_i(exception_i), .cause_i(cause_i), .pc_i(pc_i), .stall_o(stall_o),
        .dmem(dmem), .valid_o(valid_o), .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o),
        .csr_wen_o(csr_wen_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .exception_o(exception_o), .cause_o(cause_o), .pc_o(pc_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] addr, sdata;
        logic        wen;
        logic [4:0]  rd;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic [63:0] csr_wdata;
        logic        exc;
        logic [63:0] cause, pc;
        int          g, r;
        logic [63:0] rdata;
    } instr_t;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic [63:0] csr_wdata;
        logic        exc;
        logic [63:0] cause, pc;
        int          ret;
    } exp_t;

    typedef struct {
        logic [63:0] addr, wdata, rdata;
        logic        we;
        logic [7:0]  wmask;
        int          g, r;
    } mem_t;

    exp_t expq[$];
    mem_t memq[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=0x%h exp=0x%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: access width in bytes (0 = not a memory op)
    function automatic int nbytes(logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            default:           return 0;
        endcase
    endfunction

    function automatic bit is_store(logic [3:0] op);
        return op >= 4'd8 && op <= 4'd11;
    endfunction

    function automatic logic [63:0] load_val(logic [3:0] op, logic [2:0] off, logic [63:0] rdata);
        int          n = nbytes(op);
        logic [63:0] v = rdata >> (8 * int'(off));
        logic [63:0] m = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        v = v & m;
        if ((op == 4'd1 || op == 4'd2 || op == 4'd3) && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        int     n;
        x.op   = 4'($urandom_range(0, 15));
        x.addr = {$urandom, $urandom};
        n      = nbytes(x.op);
        if (n > 1 && ($urandom % 4) != 0) x.addr[2:0] = x.addr[2:0] & ~3'(n - 1);
        x.sdata     = {$urandom, $urandom};
        x.wen       = 1'($urandom);
        x.rd        = 5'($urandom);
        x.csr_wen   = 1'($urandom);
        x.csr_addr  = 12'($urandom);
        x.csr_wdata = {$urandom, $urandom};
        x.exc       = (($urandom % 8) == 0);
        x.cause     = 64'($urandom_range(0, 15));
        x.pc        = {$urandom, $urandom};
        x.g         = $urandom_range(0, 3);
        x.r         = $urandom_range(0, 3);
        x.rdata     = {$urandom, $urandom};
        return x;
    endfunction

    task automatic drive(input instr_t in);
        valid_i      = 1'b1;
        mem_op_i     = in.op;
        addr_i       = in.addr;
        store_data_i = in.sdata;
        wen_i        = in.wen;
        rd_i         = in.rd;
        csr_wen_i    = in.csr_wen;
        csr_addr_i   = in.csr_addr;
        csr_wdata_i  = in.csr_wdata;
        exception_i  = in.exc;
        cause_i      = in.cause;
        pc_i         = in.pc;
    endtask

    function automatic mem_t mem_expect(input instr_t in);
        mem_t m;
        int   n = nbytes(in.op);
        m.addr  = {in.addr[63:3], 3'b000};
        m.we    = is_store(in.op);
        m.wmask = 8'(((1 << n) - 1) << int'(in.addr[2:0]));
        m.wdata = in.sdata << (8 * int'(in.addr[2:0]));
        m.rdata = in.rdata;
        m.g     = in.g;
        m.r     = in.r;
        return m;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the DUT stops stalling
    task automatic issue(input instr_t in);
        exp_t e;
        int   n = nbytes(in.op);
        bit   mem_ok = !in.exc && n != 0 && ((in.addr[2:0] & 3'(n - 1)) == 3'd0);
        int   exp_stall = mem_ok ? 2 + in.g + in.r : 0;
        int   cnt = 0;
        e.rd = in.rd; e.csr_addr = in.csr_addr; e.csr_wdata = in.csr_wdata; e.pc = in.pc;
        e.wdata = in.addr; e.wen = 1'b0; e.csr_wen = 1'b0; e.exc = 1'b0; e.cause = '0;
        if (in.exc) begin
            e.exc = 1'b1; e.cause = in.cause;
        end else if (n == 0) begin
            e.wen = in.wen; e.csr_wen = in.csr_wen;
        end else if (!mem_ok) begin
            e.exc = 1'b1; e.cause = is_store(in.op) ? 64'd6 : 64'd4;
        end else begin
            e.csr_wen = in.csr_wen;
            if (!is_store(in.op)) begin
                e.wen = in.wen;
                e.wdata = load_val(in.op, in.addr[2:0], in.rdata);
            end
        end
        e.ret = cyc + 1 + exp_stall;
        expq.push_back(e);
        if (mem_ok) memq.push_back(mem_expect(in));
        drive(in);
        @(negedge clock); #1;
        while (stall_o === 1'b1 && cnt < 64) begin
            cnt++;
            @(posedge clock); @(negedge clock); #1;
        end
        chk("stall_cycles", 64'(cnt), 64'(exp_stall));
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        valid_i      = 1'b0;
        mem_op_i     = 4'($urandom);
        addr_i       = {$urandom, $urandom};
        exception_i  = 1'($urandom);
        wen_i        = 1'($urandom);
        csr_wen_i    = 1'($urandom);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Retire monitor: every valid_o pops one expected bundle
    exp_t mon_e;
    always @(negedge clock) begin
        if (valid_o === 1'b1) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_retire got valid_o=1 exp=no pending instruction at cycle %0d", cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("retire_cycle", 64'(cyc), 64'(mon_e.ret));
                chk("wen_o", 64'(wen_o), 64'(mon_e.wen));
                chk("rd_o", 64'(rd_o), 64'(mon_e.rd));
                chk("wdata_o", wdata_o, mon_e.wdata);
                chk("csr_wen_o", 64'(csr_wen_o), 64'(mon_e.csr_wen));
                chk("csr_addr_o", 64'(csr_addr_o), 64'(mon_e.csr_addr));
                chk("csr_wdata_o", csr_wdata_o, mon_e.csr_wdata);
                chk("exception_o", 64'(exception_o), 64'(mon_e.exc));
                chk("cause_o", cause_o, mon_e.cause);
                chk("pc_o", pc_o, mon_e.pc);
            end
        end else begin
            chk("bubble_flags", 64'({wen_o, csr_wen_o, exception_o}), 64'd0);
        end
    end

    // Memory responder: checks each request, then grants/acks after planned delays
    mem_t rsp_m;
    bit   aborted;
    initial begin
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b0 || dmem.dmem_req !== 1'b1) begin
                dmem.dmem_gnt    = (($urandom % 4) == 0);
                dmem.dmem_rvalid = (($urandom % 4) == 0);
                dmem.dmem_rdata  = {$urandom, $urandom};
                continue;
            end
            if (memq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_dmem_req got=1 exp=0 at cycle %0d", cyc);
                continue;
            end
            rsp_m = memq.pop_front();
            chk("dmem_addr", dmem.dmem_addr, rsp_m.addr);
            chk("dmem_we", 64'(dmem.dmem_we), 64'(rsp_m.we));
            if (rsp_m.we) begin
                chk("dmem_wmask", 64'(dmem.dmem_wmask), 64'(rsp_m.wmask));
                chk("dmem_wdata", dmem.dmem_wdata, rsp_m.wdata);
            end
            aborted = 1'b0;
            dmem.dmem_gnt = 1'b0;
            dmem.dmem_rvalid = 1'($urandom);
            for (int i = 0; i < rsp_m.g && !aborted; i++) begin
                @(negedge clock);
                if (reset === 1'b1) aborted = 1'b1;
                else chk("dmem_req_held", 64'(dmem.dmem_req), 64'd1);
                dmem.dmem_rvalid = 1'($urandom);
            end
            if (aborted) begin
                dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
                continue;
            end
            dmem.dmem_gnt = 1'b1; dmem.dmem_rvalid = 1'b0;
            @(negedge clock);
            dmem.dmem_gnt = 1'($urandom);
            chk("dmem_req_after_gnt", 64'(dmem.dmem_req), 64'd0);
            for (int i = 0; i < rsp_m.r; i++) begin
                @(negedge clock);
                dmem.dmem_gnt = 1'($urandom);
            end
            dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = rsp_m.rdata;
            @(negedge clock);
            dmem.dmem_rvalid = 1'b0; dmem.dmem_gnt = 1'b0;
        end
    end

    initial begin
        instr_t x;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_stall_o", 64'(stall_o), 64'd0);
        chk("reset_dmem_req", 64'(dmem.dmem_req), 64'd0);
        chk("reset_valid_o", 64'(valid_o), 64'd0);
        chk("reset_wdata_o", wdata_o, 64'd0);
        chk("reset_pc_o", pc_o, 64'd0);
        chk("reset_cause_o", cause_o, 64'd0);
        reset = 1'b0;
        idle(2);

        // LD, grant on 2nd REQ cycle, ack in 1st RESP cycle
        x = rand_instr(); x.exc = 0; x.op = 4'd4; x.addr = 64'h8000_1000; x.wen = 1; x.rd = 5'd5;
        x.g = 1; x.r = 0; x.rdata = 64'h1122_3344_5566_7788;
        issue(x);
        // LB / LBU at byte 3
        x = rand_instr(); x.exc = 0; x.op = 4'd1; x.addr = 64'h8000_2003; x.wen = 1;
        x.rdata = 64'h0000_0000_8000_0000;
        issue(x);
        x.op = 4'd5;
        issue(x);
        // SH to the top halfword
        x = rand_instr(); x.exc = 0; x.op = 4'd9; x.addr = 64'h8000_3006; x.sdata = 64'hBEEF; x.wen = 1;
        issue(x);
        // Misaligned LW
        x = rand_instr(); x.exc = 0; x.op = 4'd3; x.addr = 64'h8000_4002;
        issue(x);
        // Upstream exception on SD
        x = rand_instr(); x.exc = 1; x.op = 4'd11; x.cause = 64'd3; x.addr = 64'h8000_5000;
        issue(x);
        idle(2);

        // Reset while waiting for grant
        x = rand_instr(); x.exc = 0; x.op = 4'd4; x.addr = 64'h8000_6000; x.g = 20;
        memq.push_back(mem_expect(x));
        drive(x);
        @(negedge clock); #1;
        chk("rst_test_accept_stall", 64'(stall_o), 64'd1);
        @(posedge clock); @(negedge clock); #1;
        chk("rst_test_in_req", 64'(dmem.dmem_req), 64'd1);
        @(posedge clock); #1;
        reset = 1'b1; valid_i = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_test_dmem_req", 64'(dmem.dmem_req), 64'd0);
        chk("rst_test_stall", 64'(stall_o), 64'd0);
        chk("rst_test_valid_o", 64'(valid_o), 64'd0);
        x = rand_instr(); x.exc = 0; x.op = 4'd0;
        issue(x);

        for (int i = 0; i < 300; i++) begin
            issue(rand_instr());
            if (($urandom % 4) == 0) idle($urandom_range(1, 3));
        end

        idle(6);
        chk("pending_retires", 64'(expq.size()), 64'd0);
        chk("pending_mem_txns", 64'(memq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
